// File: rtl/conv_pkg.sv
// Shared definitions for the K=3, rate-1/2 convolutional code.
// Imported by the encoder and by the Viterbi decoder chain so both ends
// agree on the trellis, the generator polynomials and the puncturing pattern.
package conv_pkg;

    localparam int K        = 3;
    localparam int STATE_W  = K - 1;
    localparam int N_STATES = 1 << STATE_W;
    localparam int TAIL_LEN = K - 1;

    // Bit K-1 of each generator taps the current input; lower bits tap sr.
    localparam logic [K-1:0] G0_DEFAULT = 3'b111;
    localparam logic [K-1:0] G1_DEFAULT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } conv_state_e;

    // Period-2 rate-2/3 puncturing: phase 0 -> upper pair, phase 1 -> lower pair.
    localparam logic [3:0] PUNCT_PATTERN = {2'b11, 2'b01};

    function automatic logic [1:0] punct_mask(input logic phase);
        return phase ? PUNCT_PATTERN[1:0] : PUNCT_PATTERN[3:2];
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational trellis step of the convolutional code.
// Ports:
//   u       - information bit entering the encoder
//   sr      - state {s1, s0}, s1 being the previous bit
//   g0, g1  - code bits from generators G0 / G1
//   next_sr - state after shifting u in: {u, s1}
module conv_enc_core
    import conv_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic               u,
    input  logic [STATE_W-1:0] sr,
    output logic               g0,
    output logic               g1,
    output logic [STATE_W-1:0] next_sr
);

    logic [K-1:0] taps;

    assign taps    = {u, sr};
    assign g0      = ^(taps & G0);
    assign g1      = ^(taps & G1);
    assign next_sr = taps[K-1:1];

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with zero-tail termination.
// One information bit in per handshake, one {g1,g0} symbol out per handshake.
// After the bit flagged last, K-1 zero tail symbols drive the trellis back to
// state 0, which the decoder traceback assumes.
// Optional: define CONV_ENC_PUNCT_EN for rate-2/3 puncturing masks on
// information symbols (tail symbols always send both bits).
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid_i/in_ready_o, in_bit_i, in_last_i - information bit stream
//   sym_o, sym_mask_o    - code symbol and per-bit transmit mask
//   sym_valid_o/sym_ready_i, sym_tail_o        - symbol stream, tail flag
//   frame_done_o         - pulse when the final tail symbol transfers
//   sym_cnt_o            - symbols transferred in the current/last frame
//   busy_o               - encoder is inside a frame
module conv_encoder
    import conv_pkg::*;
#(
    parameter int           K     = conv_pkg::K,
    parameter logic [K-1:0] G0    = G0_DEFAULT,
    parameter logic [K-1:0] G1    = G1_DEFAULT,
    parameter int           CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_bit_i,
    input  logic             in_last_i,
    output logic [1:0]       sym_o,
    output logic [1:0]       sym_mask_o,
    output logic             sym_valid_o,
    input  logic             sym_ready_i,
    output logic             sym_tail_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] sym_cnt_o,
    output logic             busy_o
);

    localparam logic [1:0] TAIL_LAST = 2'(K - 1);

    conv_state_e      state_reg, state_next;
    logic [1:0]       sr_reg;
    logic [1:0]       tail_cnt_reg;
    logic [1:0]       sym_reg;
    logic [1:0]       mask_reg;
    logic             valid_reg;
    logic             tail_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic       slot_free, sym_xfer, in_ready, in_xfer;
    logic       tail_load, load, last_tail_xfer;
    logic       core_u, g0, g1;
    logic [1:0] next_sr;
    logic [1:0] info_mask;

    always_comb begin
        slot_free      = !valid_reg || sym_ready_i;
        sym_xfer       = valid_reg && sym_ready_i;
        // Gated by rst so the source sees no ready while reset is held.
        in_ready       = !rst && (state_reg != ST_TAIL) && slot_free;
        in_xfer        = in_valid_i && in_ready;
        tail_load      = (state_reg == ST_TAIL) && slot_free && (tail_cnt_reg != TAIL_LAST);
        load           = in_xfer || tail_load;
        // The slot holds the final tail symbol once the tail counter is full.
        last_tail_xfer = (state_reg == ST_TAIL) && sym_xfer && (tail_cnt_reg == TAIL_LAST);
        core_u         = (state_reg == ST_TAIL) ? 1'b0 : in_bit_i;
    end

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .u       (core_u),
        .sr      (sr_reg),
        .g0      (g0),
        .g1      (g1),
        .next_sr (next_sr)
    );

`ifdef CONV_ENC_PUNCT_EN
    logic phase_reg;
    logic phase_cur;

    // A bit accepted in IDLE starts a new frame, so it always uses phase 0.
    assign phase_cur = (state_reg == ST_IDLE) ? 1'b0 : phase_reg;
    assign info_mask = punct_mask(phase_cur);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= 1'b0;
        end else if (in_xfer) begin
            phase_reg <= ~phase_cur;
        end
    end
`else
    assign info_mask = 2'b11;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DATA: begin
                if (in_xfer) begin
                    state_next = in_last_i ? ST_TAIL : ST_DATA;
                end
            end
            ST_TAIL: begin
                if (last_tail_xfer) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg       <= '0;
            tail_cnt_reg <= '0;
            sym_reg      <= '0;
            mask_reg     <= 2'b11;
            valid_reg    <= 1'b0;
            tail_reg     <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            if (load) begin
                sr_reg    <= next_sr;
                sym_reg   <= {g1, g0};
                mask_reg  <= tail_load ? 2'b11 : info_mask;
                tail_reg  <= tail_load;
                valid_reg <= 1'b1;
            end else if (sym_xfer) begin
                valid_reg <= 1'b0;
            end

            if (in_xfer && in_last_i) begin
                tail_cnt_reg <= '0;
            end else if (tail_load) begin
                tail_cnt_reg <= tail_cnt_reg + 2'd1;
            end

            // The output slot is always empty in IDLE, so a frame start
            // never coincides with a downstream transfer.
            if (in_xfer && (state_reg == ST_IDLE)) begin
                cnt_reg <= '0;
            end else if (sym_xfer) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign in_ready_o   = in_ready;
    assign sym_o        = sym_reg;
    assign sym_mask_o   = mask_reg;
    assign sym_valid_o  = valid_reg;
    assign sym_tail_o   = tail_reg;
    assign frame_done_o = last_tail_xfer;
    assign sym_cnt_o    = cnt_reg;
    assign busy_o       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_conv_encoder.sv
module tb_conv_encoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic             in_bit_i = 1'b0;
    logic             in_last_i = 1'b0;
    logic [1:0]       sym_o;
    logic [1:0]       sym_mask_o;
    logic             sym_valid_o;
    logic             sym_ready_i = 1'b0;
    logic             sym_tail_o;
    logic             frame_done_o;
    logic [CNT_W-1:0] sym_cnt_o;
    logic             busy_o;

    conv_encoder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_bit_i     (in_bit_i),
        .in_last_i    (in_last_i),
        .sym_o        (sym_o),
        .sym_mask_o   (sym_mask_o),
        .sym_valid_o  (sym_valid_o),
        .sym_ready_i  (sym_ready_i),
        .sym_tail_o   (sym_tail_o),
        .frame_done_o (frame_done_o),
        .sym_cnt_o    (sym_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: symbols the encoder owes downstream, in order.
    typedef struct {
        logic [1:0] sym;
        logic [1:0] mask;
        logic       tail;
        logic       fin;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] sym_log[$];
    logic       tail_log[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         model_cnt = 0;
    int         done_seen = 0;
    bit         in_frame = 0;
    bit         acc = 0;
    bit         prev1 = 0, prev2 = 0;   // u(t-1), u(t-2)
    bit         phase = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t encode(input bit u, input bit is_tail, input bit fin);
        exp_t e;
        bit c0, c1;
        c0 = u ^ prev1 ^ prev2;
        c1 = u ^ prev2;
        e.sym  = {c1, c0};
        e.tail = is_tail;
        e.fin  = fin;
`ifdef CONV_ENC_PUNCT_EN
        e.mask = (is_tail || !phase) ? 2'b11 : 2'b01;
`else
        e.mask = 2'b11;
`endif
        prev2 = prev1;
        prev1 = u;
        return e;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic v, input logic b, input logic l, input logic r);
        bit rdy_exp, xfer;
        exp_t e;
        in_valid_i  = v;
        in_bit_i    = b;
        in_last_i   = l;
        sym_ready_i = r;
        #1;
        rdy_exp = (exp_q.size() == 0) ||
                  (exp_q.size() == 1 && !exp_q[0].tail && r);
        xfer = r && (exp_q.size() > 0);
        chk("sym_valid", 32'(sym_valid_o), 32'(exp_q.size() > 0));
        chk("in_ready", 32'(in_ready_o), 32'(rdy_exp));
        chk("busy", 32'(busy_o), 32'(in_frame));
        chk("sym_cnt", 32'(sym_cnt_o), 32'(model_cnt & 16'hFFFF));
        chk("frame_done", 32'(frame_done_o), 32'(xfer && exp_q[0].fin));
        if (exp_q.size() > 0) begin
            chk("sym", 32'(sym_o), 32'(exp_q[0].sym));
            chk("sym_mask", 32'(sym_mask_o), 32'(exp_q[0].mask));
            chk("sym_tail", 32'(sym_tail_o), 32'(exp_q[0].tail));
        end
        if (frame_done_o) done_seen++;
        if (xfer) begin
            sym_log.push_back(sym_o);
            tail_log.push_back(sym_tail_o);
            e = exp_q.pop_front();
            model_cnt++;
            if (e.fin) in_frame = 0;
        end
        acc = v && rdy_exp;
        if (acc) begin
            if (!in_frame) begin
                model_cnt = 0;
                prev1 = 0; prev2 = 0; phase = 0;
                in_frame = 1;
            end
            exp_q.push_back(encode(b, 1'b0, 1'b0));
            phase = ~phase;
            if (l) begin
                exp_q.push_back(encode(1'b0, 1'b1, 1'b0));
                exp_q.push_back(encode(1'b0, 1'b1, 1'b1));
            end
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic l, input int rdy_pct, input int val_pct);
        for (int t = 0; t < 60; t++) begin
            cycle(($urandom_range(99) < val_pct) ? 1'b1 : 1'b0, b, l,
                  ($urandom_range(99) < rdy_pct) ? 1'b1 : 1'b0);
            if (acc) return;
        end
        chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain(input int rdy_pct);
        for (int t = 0; t < 200 && in_frame; t++) begin
            cycle($urandom_range(1) != 0, $urandom_range(1) != 0, 1'b0,
                  ($urandom_range(99) < rdy_pct) ? 1'b1 : 1'b0);
        end
        chk("drain_timeout", 32'(in_frame), 32'd0);
    endtask

    task automatic check_ref_frame(input string tag);
        logic [1:0] ref_sym [6];
        logic       ref_tail[6];
        ref_sym  = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
        ref_tail = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        chk({tag, "_len"}, 32'(sym_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < sym_log.size(); i++) begin
            chk($sformatf("%s_sym%0d", tag, i), 32'(sym_log[i]), 32'(ref_sym[i]));
            chk($sformatf("%s_tail%0d", tag, i), 32'(tail_log[i]), 32'(ref_tail[i]));
        end
        chk({tag, "_cnt"}, 32'(sym_cnt_o), 32'd6);
        chk({tag, "_done"}, 32'(done_seen), 32'd1);
    endtask

    task automatic clear_logs();
        sym_log.delete();
        tail_log.delete();
        done_seen = 0;
    endtask

    initial begin
        logic [1:0] held;
        int len;

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        chk("rst_valid", 32'(sym_valid_o), 32'd0);
        chk("rst_sym", 32'(sym_o), 32'd0);
        chk("rst_mask", 32'(sym_mask_o), 32'd3);
        chk("rst_tail", 32'(sym_tail_o), 32'd0);
        chk("rst_done", 32'(frame_done_o), 32'd0);
        chk("rst_cnt", 32'(sym_cnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready_o), 32'd1);
        chk("rel_busy", 32'(busy_o), 32'd0);
        $display("step reset: done");

        // Frame 1,0,1,1 with downstream always ready.
        clear_logs();
        send_bit(1'b1, 1'b0, 100, 100);
        send_bit(1'b0, 1'b0, 100, 100);
        send_bit(1'b1, 1'b0, 100, 100);
        send_bit(1'b1, 1'b1, 100, 100);
        drain(100);
        check_ref_frame("frame1011");
        $display("step frame 1011: %0d symbols", sym_log.size());

        // Same frame with a 3-cycle downstream stall after the second bit.
        clear_logs();
        send_bit(1'b1, 1'b0, 100, 100);
        send_bit(1'b0, 1'b0, 100, 100);
        held = sym_o;
        for (int s = 0; s < 3; s++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            chk("stall_no_accept", 32'(acc), 32'd0);
            chk("stall_stable", 32'(sym_o), 32'(held));
        end
        send_bit(1'b1, 1'b0, 100, 100);
        send_bit(1'b1, 1'b1, 100, 100);
        drain(100);
        check_ref_frame("stall");
        $display("step backpressure: %0d symbols", sym_log.size());

        // Single-bit frame.
        clear_logs();
        send_bit(1'b1, 1'b1, 100, 100);
        drain(100);
        chk("single_len", 32'(sym_log.size()), 32'd3);
        chk("single_done", 32'(done_seen), 32'd1);
        chk("single_busy", 32'(busy_o), 32'd0);
        $display("step single-bit frame: %0d symbols", sym_log.size());

        // Asynchronous reset while the tail is being emitted.
        send_bit(1'b1, 1'b0, 100, 100);
        send_bit(1'b1, 1'b1, 100, 100);
        chk("pre_rst_tail_state", 32'(busy_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(sym_valid_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_cnt", 32'(sym_cnt_o), 32'd0);
        chk("mid_rst_tail", 32'(sym_tail_o), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready_o), 32'd0);
        exp_q.delete();
        in_frame = 0;
        model_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        send_bit(1'b1, 1'b0, 100, 100);
        send_bit(1'b0, 1'b0, 100, 100);
        send_bit(1'b1, 1'b0, 100, 100);
        send_bit(1'b1, 1'b1, 100, 100);
        drain(100);
        check_ref_frame("after_rst");
        $display("step mid-frame reset: %0d symbols", sym_log.size());

        // Random frames with random valid/ready activity.
        for (int f = 0; f < 40; f++) begin
            clear_logs();
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                send_bit($urandom_range(1) != 0, (i == len - 1), 70, 70);
            end
            drain(70);
            chk("rand_len", 32'(sym_log.size()), 32'(len + 2));
            chk("rand_done", 32'(done_seen), 32'd1);
            $display("step random frame %0d: %0d bits, %0d symbols", f, len, sym_log.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
